// File: rtl/serial_link_peer.sv
// Far-end partner for the Game Boy link port: exchanges one byte per transfer, MSB first,
// either following the console's shift clock (slave) or generating it (master).
module serial_link_peer #(
  parameter int CLK_DIV        = 256,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       master_mode,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       timeout_err,
  input  logic       sck_in,
  output logic       sck_out,
  input  logic       sdata_in,
  output logic       sdata_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic             mode_master;
  logic             sck_s1, sck_s2, sck_prev, fall_det, rise_det;
  logic             sd_s1, sd_s2;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic             tail;
  logic [DIV_W-1:0] div_cnt;
  logic [TO_W-1:0]  idle_cnt;
  logic [7:0]       hold_data;
  logic             hold_full;
  logic             hold_used;

  logic       gen_tick, do_fall, do_rise, go;
  logic [7:0] load_byte;

  assign tx_ready = ~hold_full;

  always_comb begin
    gen_tick  = mode_master && (div_cnt == DIV_LAST);
    do_fall   = (state == ST_SHIFT) && (mode_master ? (gen_tick && sck_out && !tail) : fall_det);
    do_rise   = (state == ST_SHIFT) && (mode_master ? (gen_tick && !sck_out) : rise_det);
    go        = master_mode ? start : fall_det;
    load_byte = hold_full ? hold_data : 8'hFF;
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode_master <= 1'b0;
      sck_s1      <= 1'b1;
      sck_s2      <= 1'b1;
      sck_prev    <= 1'b1;
      fall_det    <= 1'b0;
      rise_det    <= 1'b0;
      sd_s1       <= 1'b1;
      sd_s2       <= 1'b1;
      shreg       <= 8'hFF;
      bit_cnt     <= '0;
      tail        <= 1'b0;
      div_cnt     <= '0;
      idle_cnt    <= '0;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      hold_used   <= 1'b0;
      sck_out     <= 1'b1;
      sdata_out   <= 1'b1;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sck_s1      <= sck_in;
      sck_s2      <= sck_s1;
      sck_prev    <= sck_s2;
      fall_det    <= sck_prev & ~sck_s2;
      rise_det    <= ~sck_prev & sck_s2;
      sd_s1       <= sdata_in;
      sd_s2       <= sd_s1;
      rx_valid    <= 1'b0;
      timeout_err <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (go) begin
            // A byte accepted this same cycle is not yet visible here, so it waits for the next transfer.
            state       <= ST_SHIFT;
            mode_master <= master_mode;
            hold_used   <= hold_full;
            sdata_out   <= load_byte[7];
            shreg       <= {load_byte[6:0], 1'b0};
            bit_cnt     <= '0;
            tail        <= 1'b0;
            div_cnt     <= '0;
            idle_cnt    <= '0;
            busy        <= 1'b1;
            if (master_mode) sck_out <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (mode_master) begin
            div_cnt <= gen_tick ? '0 : div_cnt + 1'b1;
            if (gen_tick) begin
              if (sck_out && tail) begin
                // Last high level has been held its full period: transfer complete.
                state    <= ST_DONE;
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                busy     <= 1'b0;
              end else begin
                sck_out <= ~sck_out;
              end
            end
          end else begin
            if (fall_det || rise_det) begin
              idle_cnt <= '0;
            end else if (idle_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              state       <= ST_IDLE;
              busy        <= 1'b0;
              sdata_out   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end

          if (do_fall) begin
            sdata_out <= shreg[7];
            shreg     <= {shreg[6:0], 1'b0};
          end

          if (do_rise) begin
            shreg[0] <= sd_s2;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (mode_master) begin
                tail <= 1'b1;
              end else begin
                state    <= ST_DONE;
                rx_data  <= {shreg[7:1], sd_s2};
                rx_valid <= 1'b1;
                busy     <= 1'b0;
              end
            end
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          hold_used <= 1'b0;
          if (hold_used) hold_full <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_peer.sv
// Randomized bench for serial_link_peer: plays the console side in both clock modes and
// compares against a byte-level model of the holding register and the exchange.
module tb_serial_link_peer;

  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       reset, master_mode, start, tx_valid, sck_in, sdata_drv, loopback;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, timeout_err, sck_out, sdata_out;
  logic [7:0] rx_data;
  logic       sdata_in;

  assign sdata_in = loopback ? sdata_out : sdata_drv;

  serial_link_peer #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .master_mode(master_mode), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .timeout_err(timeout_err),
    .sck_in(sck_in), .sck_out(sck_out), .sdata_in(sdata_in), .sdata_out(sdata_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt   = 0;
  int tout_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  // Byte-level model of the holding register.
  logic       model_full = 1'b0;
  logic [7:0] model_byte = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_last = rx_data;
    end
    if (timeout_err) tout_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] b);
    check("tx_ready_before_load", tx_ready, !model_full);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    model_full = 1'b1;
    model_byte = b;
    check("tx_ready_after_load", tx_ready, 0);
  endtask

  // Console-driven transfer: falls set the console bit, the peer's bit is read just before each rise.
  task automatic slave_xfer(input string tag, input logic [7:0] cb, input int h,
                            input bit inject, input logic [7:0] inj);
    logic [7:0] exp_sent, seen;
    int rx0;
    exp_sent = model_full ? model_byte : 8'hFF;
    rx0 = rx_cnt;
    seen = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sck_in = 1'b0;
      sdata_drv = cb[i];
      if (inject && i == 7) begin
        // Fall detect is registered three edges after the pin change.
        repeat (3) tick();
        tx_data = inj;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (h - 4) tick();
      end else begin
        repeat (h) tick();
      end
      seen[i] = sdata_out;
      sck_in = 1'b1;
      repeat (h) tick();
    end
    repeat (3) tick();
    model_full = 1'b0;
    if (inject) begin
      model_full = 1'b1;
      model_byte = inj;
    end
    check({tag, "_sent"}, seen, exp_sent);
    check({tag, "_rx_pulses"}, rx_cnt - rx0, 1);
    check({tag, "_rx_data"}, rx_last, cb);
    check({tag, "_tx_ready"}, tx_ready, !model_full);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Peer-driven transfer with sdata looped back, so the received byte equals the sent byte.
  task automatic master_xfer(input string tag, input bit collide);
    logic [7:0] exp_sent, sent;
    logic prev, cur;
    int busy_cyc, falls, run, bad, rx0;
    exp_sent = model_full ? model_byte : 8'hFF;
    rx0 = rx_cnt;
    loopback = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    prev = 1'b1; cur = 1'b0; sent = 8'h00;
    busy_cyc = 0; falls = 0; run = 0; bad = 0;
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      busy_cyc++;
      if (sck_out == prev) begin
        run++;
      end else begin
        if (n > 0 && run != CLK_DIV) bad++;
        if (!sck_out) falls++;
        else sent = {sent[6:0], cur};
        run = 1;
      end
      if (!sck_out) cur = sdata_out;
      prev = sck_out;
      start = (collide && n == 20);
      tick();
    end
    start = 1'b0;
    if (run != CLK_DIV) bad++;
    repeat (3) tick();
    loopback = 1'b0;
    model_full = 1'b0;
    check({tag, "_busy_cycles"}, busy_cyc, 8 * 2 * CLK_DIV);
    check({tag, "_sck_pulses"}, falls, 8);
    check({tag, "_bad_levels"}, bad, 0);
    check({tag, "_sent"}, sent, exp_sent);
    check({tag, "_rx_pulses"}, rx_cnt - rx0, 1);
    check({tag, "_rx_data"}, rx_last, exp_sent);
    check({tag, "_sck_idle"}, sck_out, 1);
    check({tag, "_tx_ready"}, tx_ready, 1);
  endtask

  initial begin
    int t, rx0, to0;
    logic [7:0] r;
    reset = 1'b1; master_mode = 1'b0; start = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    sck_in = 1'b1; sdata_drv = 1'b1; loopback = 1'b0;
    repeat (3) tick();
    check("rst_sck_out", sck_out, 1);
    check("rst_sdata_out", sdata_out, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    reset = 1'b0;
    repeat (4) tick();

    load_tx(8'hA5);
    slave_xfer("slave_a5", 8'h3C, 8, 1'b0, 8'h00);
    slave_xfer("slave_empty", 8'h00, 8, 1'b0, 8'h00);

    // Byte offered in the same cycle as the first fall detect rides the next transfer.
    slave_xfer("collide_a", 8'h96, 8, 1'b1, 8'hC3);
    slave_xfer("collide_a_next", 8'h0F, 8, 1'b0, 8'h00);

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      slave_xfer("slave_rand", 8'($urandom), $urandom_range(6, 12), 1'b0, 8'h00);
    end

    // Abandoned transfer: three pulses then SCK held high.
    load_tx(8'h55);
    rx0 = rx_cnt;
    to0 = tout_cnt;
    for (int k = 0; k < 3; k++) begin
      sck_in = 1'b0;
      sdata_drv = 1'($urandom);
      repeat (8) tick();
      sck_in = 1'b1;
      if (k < 2) repeat (8) tick();
    end
    t = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (timeout_err) begin
        t = n;
        break;
      end
    end
    check("timeout_in_window", (t >= TIMEOUT - 2 && t <= TIMEOUT + 6), 1);
    tick();
    check("timeout_single_pulse", timeout_err, 0);
    check("timeout_count", tout_cnt - to0, 1);
    check("timeout_no_rx", rx_cnt - rx0, 0);
    check("timeout_tx_ready", tx_ready, 0);
    check("timeout_busy", busy, 0);
    check("timeout_sdata_idle", sdata_out, 1);
    repeat (4) tick();
    slave_xfer("after_timeout", 8'hE7, 8, 1'b0, 8'h00);

    master_mode = 1'b1;
    tick();
    load_tx(8'h81);
    master_xfer("master_81", 1'b1);
    for (int k = 0; k < 2; k++) begin
      load_tx(8'($urandom));
      master_xfer("master_rand", 1'b0);
    end
    master_xfer("master_empty", 1'b0);

    // Slave transfer cut by reset after four bits.
    master_mode = 1'b0;
    tick();
    r = 8'($urandom);
    load_tx(r);
    rx0 = rx_cnt;
    to0 = tout_cnt;
    for (int i = 7; i >= 4; i--) begin
      sck_in = 1'b0;
      sdata_drv = 1'($urandom);
      repeat (8) tick();
      sck_in = 1'b1;
      repeat (8) tick();
    end
    reset = 1'b1;
    tick();
    check("midrst_sck_out", sck_out, 1);
    check("midrst_sdata_out", sdata_out, 1);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_timeout", timeout_err, 0);
    reset = 1'b0;
    model_full = 1'b0;
    repeat (60) tick();
    check("midrst_no_rx", rx_cnt - rx0, 0);
    check("midrst_no_timeout", tout_cnt - to0, 0);
    slave_xfer("after_reset", 8'h5A, 8, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
